// File: rtl/counter_job_scheduler.sv
// counter_job_scheduler: round-robin arbiter and sequencer for two counting
// jobs. It drives the load/clear/mode/enable controls of an external up/down
// counter and returns the counter value once a job completes.
module counter_job_scheduler #(
    parameter int W = 4,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [W-1:0] start_a,
    input  logic [W-1:0] start_b,
    input  logic         up_a,
    input  logic         up_b,
    input  logic [S-1:0] steps_a,
    input  logic [S-1:0] steps_b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         done_a,
    output logic         done_b,
    output logic [W-1:0] result,
    output logic         busy,
    output logic [W-1:0] cnt_data_in,
    output logic         cnt_load,
    output logic         cnt_clear,
    output logic         cnt_mode,
    output logic         cnt_enable,
    input  logic [W-1:0] cnt_value
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic         owner;      // 0 = A, 1 = B
    logic         rr_ptr;     // 0 = A preferred on contention
    logic [S-1:0] step_cnt;
    logic [W-1:0] l_start;
    logic         l_up;
    logic [S-1:0] l_steps;
    logic         pick_b;

    // B wins when it is the only requester or when both ask and rr points at B.
    assign pick_b = req_b & (~req_a | rr_ptr);

    // Clear is the only control not decoded from registered state.
    assign cnt_clear = ~rst_n | flush;

    // State register plus job latches, step counter, result and rr pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_ptr   <= 1'b0;
            step_cnt <= '0;
            l_start  <= '0;
            l_up     <= 1'b0;
            l_steps  <= '0;
            result   <= '0;
        end else begin
            state <= state_nxt;
            // A flush leaves every datapath register untouched.
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (req_a | req_b) begin
                            owner   <= pick_b;
                            l_start <= pick_b ? start_b : start_a;
                            l_up    <= pick_b ? up_b    : up_a;
                            l_steps <= pick_b ? steps_b : steps_a;
                        end
                    end
                    LOAD: step_cnt <= l_steps;
                    RUN:  step_cnt <= step_cnt - S'(1);
                    DONE: begin
                        result <= cnt_value;
                        rr_ptr <= ~rr_ptr;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_a | req_b) state_nxt = LOAD;
            LOAD: state_nxt = (l_steps == '0) ? DONE : RUN;
            RUN:  if (step_cnt == S'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Output decode from registered state, owner and latched job fields.
    always_comb begin
        busy        = (state != IDLE);
        gnt_a       = busy & ~owner;
        gnt_b       = busy &  owner;
        done_a      = (state == DONE) & ~owner;
        done_b      = (state == DONE) &  owner;
        cnt_load    = (state == LOAD);
        cnt_data_in = (state == LOAD) ? l_start : '0;
        cnt_enable  = (state == RUN);
        cnt_mode    = (state == RUN) & l_up;
    end

endmodule

// File: tb/tb_counter_job_scheduler.sv
// Bench for counter_job_scheduler: a behavioural 4-bit counter closes the
// loop, directed and random jobs are checked against expected results,
// latencies, grant order and control-pulse counts.
module tb_counter_job_scheduler;

    localparam int W = 4;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n, flush;
    logic         req_a, req_b, up_a, up_b;
    logic [W-1:0] start_a, start_b;
    logic [S-1:0] steps_a, steps_b;
    logic         gnt_a, gnt_b, done_a, done_b, busy;
    logic [W-1:0] result, cnt_data_in, cnt_value;
    logic         cnt_load, cnt_clear, cnt_mode, cnt_enable;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    bit exp_rr  = 1'b0;   // 0 = A preferred next on contention

    counter_job_scheduler #(.W(W), .S(S)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_a(req_a), .req_b(req_b),
        .start_a(start_a), .start_b(start_b),
        .up_a(up_a), .up_b(up_b),
        .steps_a(steps_a), .steps_b(steps_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .result(result), .busy(busy),
        .cnt_data_in(cnt_data_in), .cnt_load(cnt_load), .cnt_clear(cnt_clear),
        .cnt_mode(cnt_mode), .cnt_enable(cnt_enable), .cnt_value(cnt_value)
    );

    always #5 clk = ~clk;

    // Behavioural universal counter: clear > load > enable.
    always @(posedge clk) begin
        if (cnt_clear)       cnt_value <= '0;
        else if (cnt_load)   cnt_value <= cnt_data_in;
        else if (cnt_enable) cnt_value <= cnt_mode ? cnt_value + 4'd1 : cnt_value - 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] st, input bit up, input logic [S-1:0] sp);
        int v;
        v = up ? (int'(st) + int'(sp)) : (int'(st) - int'(sp) + 16);
        return W'(v % 16);
    endfunction

    task automatic set_job(input bit b, input logic [W-1:0] st, input bit up, input logic [S-1:0] sp);
        if (b) begin start_b = st; up_b = up; steps_b = sp; req_b = 1'b1; end
        else   begin start_a = st; up_a = up; steps_a = sp; req_a = 1'b1; end
    endtask

    // Runs one job and checks it. Caller has either raised the request (pre=1)
    // or wants this task to raise it; the DUT must be idle.
    task automatic run_job(input bit b, input logic [W-1:0] st, input bit up,
                           input logic [S-1:0] sp, input bit contended);
        int  n = 0, loads = 0, ens = 0;
        bit  seen = 0, both = 0;
        logic [W-1:0] exp_res;
        exp_res = model(st, up, sp);
        if (!contended) set_job(b, st, up, sp);
        while (!seen && n < 40) begin
            tick();
            n++;
            if (n == 1) begin
                chk("gnt_owner_T1", b ? gnt_b : gnt_a, 1);
                chk("gnt_other_T1", b ? gnt_a : gnt_b, 0);
                chk("busy_T1", busy, 1);
                chk("load_data", cnt_data_in, st);
            end
            loads += int'(cnt_load);
            ens   += int'(cnt_enable);
            if (gnt_a && gnt_b) both = 1;
            if (done_a || done_b) seen = 1;
        end
        chk("done_seen", seen, 1);
        chk("latency", n, sp + 2);
        chk("done_owner", b ? done_b : done_a, 1);
        chk("load_pulses", loads, 1);
        chk("enable_cycles", ens, sp);
        if (contended) chk("never_both_gnt", both, 0);
        if (b) req_b = 1'b0; else req_a = 1'b0;
        exp_rr = ~exp_rr;
        tick();
        chk("result", result, exp_res);
        chk("idle_after_done", busy, 0);
    endtask

    // Both requesters ask continuously; grants must alternate per rr.
    task automatic run_pair(input int jobs);
        logic [W-1:0] sa, sb;
        logic [S-1:0] pa, pb;
        bit ua, ub, who;
        sa = W'($urandom); sb = W'($urandom);
        pa = S'($urandom_range(0, 6)); pb = S'($urandom_range(0, 6));
        ua = 1'($urandom); ub = 1'($urandom);
        set_job(1'b0, sa, ua, pa);
        set_job(1'b1, sb, ub, pb);
        for (int j = 0; j < jobs; j++) begin
            who = exp_rr;
            run_job(who, who ? sb : sa, who ? ub : ua, who ? pb : pa, 1'b1);
            if (j < jobs - 1) begin
                if (who) req_b = 1'b1; else req_a = 1'b1;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
    endtask

    initial begin
        int  n;
        bit  dn;
        logic [W-1:0] res_before;
        rst_n = 1'b0; flush = 1'b0; req_a = 1'b0; req_b = 1'b0;
        start_a = '0; start_b = '0; up_a = 1'b0; up_b = 1'b0;
        steps_a = '0; steps_b = '0;

        // Reset values.
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {gnt_a, gnt_b}, 0);
        chk("rst_done", {done_a, done_b}, 0);
        chk("rst_ctrl", {cnt_load, cnt_enable, cnt_mode}, 0);
        chk("rst_data", cnt_data_in, 0);
        chk("rst_result", result, 0);
        chk("rst_clear", cnt_clear, 1);
        rst_n = 1'b1;
        tick();
        chk("clear_released", cnt_clear, 0);

        // Directed jobs.
        run_job(1'b0, 4'd3, 1'b1, 4'd5, 1'b0);   // 8
        run_job(1'b1, 4'd2, 1'b0, 4'd4, 1'b0);   // 14, wraps
        run_job(1'b0, 4'd9, 1'b1, 4'd0, 1'b0);   // zero steps
        run_job(1'b1, 4'd14, 1'b1, 4'd15, 1'b0); // max length, wraps up

        // Contention fairness.
        run_pair(4);

        // Flush on the third RUN cycle of a 10-step job.
        res_before = result;
        set_job(1'b0, 4'd1, 1'b1, 4'd10);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_a || done_b) dn = 1;
        end
        chk("flush_in_run", cnt_enable, 1);
        flush = 1'b1;
        #1;
        chk("flush_clear", cnt_clear, 1);
        tick();
        flush = 1'b0;
        req_a = 1'b0;
        chk("flush_idle", busy, 0);
        chk("flush_gnt", {gnt_a, gnt_b}, 0);
        chk("flush_done", {done_a, done_b} | 2'(dn), 0);
        chk("flush_result", result, res_before);
        chk("flush_counter_cleared", cnt_value, 0);
        tick();
        run_pair(2);   // rr pointer must be where it was before the flush

        // Reset pulse in mid-job.
        set_job(1'b1, 4'd7, 1'b0, 4'd8);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_clear", cnt_clear, 1);
        tick();
        rst_n = 1'b1;
        req_b = 1'b0;
        exp_rr = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_gnt_done", {gnt_a, gnt_b, done_a, done_b}, 0);
        chk("rst_mid_ctrl", {cnt_load, cnt_enable, cnt_mode, cnt_data_in}, 0);
        chk("rst_mid_result", result, 0);
        tick();
        run_pair(2);   // A first after reset

        // Random single jobs.
        for (int k = 0; k < 8; k++) begin
            run_job(1'($urandom), W'($urandom), 1'($urandom), S'($urandom_range(0, 15)), 1'b0);
        end

        // Nothing stays busy with no requests.
        n = 0;
        tick();
        chk("quiet_end", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
